// File: rtl/nfc_cmd_arbiter_if.sv
// Command port between the arbiter and the NAND flash memory controller.
// master = arbiter side (issues commands), slave = memory controller side.
interface nfc_cmd_arbiter_if #(
    parameter int CMD_W  = 3,
    parameter int ADDR_W = 16
);
    logic              nfc_start;
    logic [CMD_W-1:0]  nfc_cmd;
    logic [ADDR_W-1:0] RWA;
    logic              nfc_done;
    logic              command_error;

    modport master (
        output nfc_start, nfc_cmd, RWA,
        input  nfc_done, command_error
    );

    modport slave (
        input  nfc_start, nfc_cmd, RWA,
        output nfc_done, command_error
    );
endinterface

// File: rtl/nfc_cmd_arbiter.sv
// Round-robin arbiter sharing one NAND flash controller command port among
// NUM_REQ requesters, with a completion watchdog and per-requester responses.
module nfc_cmd_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int CMD_W          = 3,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      Reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*CMD_W-1:0]  req_cmd,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [NUM_REQ-1:0]        err,
    nfc_cmd_arbiter_if.master         nfc,
    output logic                      busy,
    output logic                      timeout_flag,
    input  logic                      timeout_clr
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDX_W:0]       NREQ     = (IDX_W+1)'(NUM_REQ);
    localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_REQ-1:0]   ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   win_q;
    logic [CMD_W-1:0]   cmd_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [TMR_W-1:0]   timer_q;
    logic               err_r;
    logic               timeout_hit;

    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;

    logic [CMD_W-1:0]   cmd_slice  [NUM_REQ];
    logic [ADDR_W-1:0]  addr_slice [NUM_REQ];

    // (base + step) mod NUM_REQ, valid for base, step < NUM_REQ
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] base,
                                                  input logic [IDX_W:0]   step);
        logic [IDX_W:0] sum;
        sum = {1'b0, base} + step;
        if (sum >= NREQ) sum = sum - NREQ;
        return sum[IDX_W-1:0];
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign cmd_slice[g]  = req_cmd[g*CMD_W +: CMD_W];
        assign addr_slice[g] = req_addr[g*ADDR_W +: ADDR_W];
    end

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = wrap_inc(rr_ptr, (IDX_W+1)'(i));
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_vld) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (nfc.nfc_done || timer_q == TMR_LAST) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // nfc_done takes priority over an expiring watchdog in the same cycle
    assign timeout_hit = (state_q == WAIT) && !nfc.nfc_done && (timer_q == TMR_LAST);

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rr_ptr       <= '0;
            win_q        <= '0;
            cmd_q        <= '0;
            addr_q       <= '0;
            timer_q      <= '0;
            err_r        <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            if (state_q == IDLE && pick_vld) begin
                win_q   <= pick_idx;
                cmd_q   <= cmd_slice[pick_idx];
                addr_q  <= addr_slice[pick_idx];
                timer_q <= '0;
            end
            if (state_q == WAIT) begin
                if (timer_q != '1) timer_q <= timer_q + 1'b1;
                if (nfc.nfc_done)  err_r <= nfc.command_error;
                else if (timer_q == TMR_LAST) err_r <= 1'b1;
            end
            if (state_q == RESP) rr_ptr <= wrap_inc(win_q, (IDX_W+1)'(1));
            if (timeout_hit)      timeout_flag <= 1'b1;
            else if (timeout_clr) timeout_flag <= 1'b0;
        end
    end

    assign gnt  = (state_q == ISSUE)         ? (ONE_HOT0 << win_q) : '0;
    assign done = (state_q == RESP)          ? (ONE_HOT0 << win_q) : '0;
    assign err  = (state_q == RESP && err_r) ? (ONE_HOT0 << win_q) : '0;
    assign busy = (state_q != IDLE);

    assign nfc.nfc_start = (state_q == ISSUE);
    assign nfc.nfc_cmd   = cmd_q;
    assign nfc.RWA       = addr_q;

endmodule

// File: tb/tb_nfc_cmd_arbiter.sv
// Scoreboard bench for nfc_cmd_arbiter: 2 requesters, 8-cycle watchdog,
// behavioural memory-controller responder.
module tb_nfc_cmd_arbiter;
    localparam int NUM_REQ = 2;
    localparam int CMD_W   = 3;
    localparam int ADDR_W  = 16;
    localparam int TMO     = 8;

    typedef struct {
        logic [1:0]  gnt;
        logic [2:0]  cmd;
        logic [15:0] addr;
    } gexp_t;

    typedef struct {
        logic [1:0] done;
        logic [1:0] err;
        logic       tf;
        int         lat;
    } rexp_t;

    logic        clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [1:0]  req = '0;
    logic [5:0]  req_cmd = '0;
    logic [31:0] req_addr = '0;
    logic [1:0]  gnt, done, err;
    logic        busy, timeout_flag;
    logic        timeout_clr = 1'b0;

    nfc_cmd_arbiter_if #(.CMD_W(CMD_W), .ADDR_W(ADDR_W)) nfc_bus ();

    nfc_cmd_arbiter #(
        .NUM_REQ(NUM_REQ), .CMD_W(CMD_W), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .Reset_n(Reset_n), .req(req), .req_cmd(req_cmd), .req_addr(req_addr),
        .gnt(gnt), .done(done), .err(err), .nfc(nfc_bus.master), .busy(busy),
        .timeout_flag(timeout_flag), .timeout_clr(timeout_clr)
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    start_cyc = 0;
    int    mc_delay = 0;
    logic  mc_err = 1'b0;
    logic  tf_model = 1'b0;
    gexp_t gq[$];
    rexp_t rq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // memory controller: nfc_done sampled on WAIT cycle mc_delay (0 = never)
    initial begin : responder
        nfc_bus.nfc_done = 1'b0;
        nfc_bus.command_error = 1'b0;
        forever begin
            @(negedge clk);
            if (nfc_bus.nfc_start && mc_delay > 0) begin
                repeat (mc_delay) @(negedge clk);
                nfc_bus.nfc_done = 1'b1;
                nfc_bus.command_error = mc_err;
                @(negedge clk);
                nfc_bus.nfc_done = 1'b0;
                nfc_bus.command_error = 1'b0;
            end
        end
    end

    initial begin : monitor
        gexp_t g;
        rexp_t r;
        logic  gnt_prev;
        gnt_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (gnt_prev) chk("gnt_pulse_width", {29'd0, gnt, nfc_bus.nfc_start}, 0);
            gnt_prev = (|gnt) || nfc_bus.nfc_start;
            if (gnt_prev) begin
                if (gq.size() == 0) chk("gnt_unexpected", 32'(gnt), 0);
                else begin
                    g = gq.pop_front();
                    chk("gnt", 32'(gnt), 32'(g.gnt));
                    chk("nfc_start", 32'(nfc_bus.nfc_start), 1);
                    chk("nfc_cmd", 32'(nfc_bus.nfc_cmd), 32'(g.cmd));
                    chk("RWA", 32'(nfc_bus.RWA), 32'(g.addr));
                    chk("busy_issue", 32'(busy), 1);
                    start_cyc = cyc;
                end
            end
            if ((|done) || (|err)) begin
                if (rq.size() == 0) chk("done_unexpected", {28'd0, done, err}, 0);
                else begin
                    r = rq.pop_front();
                    chk("done", 32'(done), 32'(r.done));
                    chk("err", 32'(err), 32'(r.err));
                    chk("timeout_flag_resp", 32'(timeout_flag), 32'(r.tf));
                    chk("start_to_done", 32'(cyc - start_cyc), 32'(r.lat));
                end
            end
        end
    end

    // One request from requester w; d = WAIT cycle on which nfc_done is sampled (0 = never)
    task automatic run_txn(input int w, input logic [2:0] cmd, input logic [15:0] addr,
                           input int d, input logic e, output int waited);
        gexp_t g;
        rexp_t r;
        bit    tmo;
        bit    seen;
        tmo = (d == 0) || (d > TMO);
        g.gnt = 2'(1 << w);
        g.cmd = cmd;
        g.addr = addr;
        gq.push_back(g);
        if (tmo) tf_model = 1'b1;
        r.done = g.gnt;
        r.err = (tmo || e) ? g.gnt : 2'b00;
        r.tf = tf_model;
        r.lat = tmo ? TMO + 1 : d + 1;
        rq.push_back(r);
        mc_delay = d;
        mc_err = e;
        req_cmd[w*3 +: 3] = cmd;
        req_addr[w*16 +: 16] = addr;
        req[w] = 1'b1;
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < 10) begin
            @(negedge clk);
            waited++;
            seen = gnt[w];
        end
        chk("gnt_wait", 32'(seen), 1);
        req[w] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = done[w];
        end
        chk("done_wait", 32'(seen), 1);
    endtask

    initial begin : stim
        gexp_t g;
        rexp_t r;
        int    waited, n, cnt;
        bit    seen;

        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_nfc_start", 32'(nfc_bus.nfc_start), 0);
        chk("rst_nfc_cmd", 32'(nfc_bus.nfc_cmd), 0);
        chk("rst_RWA", 32'(nfc_bus.RWA), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_timeout_flag", 32'(timeout_flag), 0);
        Reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy), 0);

        // round-robin with both requests held
        mc_delay = 1;
        mc_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            g.gnt  = (i % 2 == 0) ? 2'b01 : 2'b10;
            g.cmd  = (i % 2 == 0) ? 3'b101 : 3'b011;
            g.addr = (i % 2 == 0) ? 16'hAAAA : 16'hBBBB;
            gq.push_back(g);
            r.done = g.gnt;
            r.err = 2'b00;
            r.tf = 1'b0;
            r.lat = 2;
            rq.push_back(r);
        end
        req_cmd = {3'b011, 3'b101};
        req_addr = {16'hBBBB, 16'hAAAA};
        req = 2'b11;
        n = 0;
        cnt = 0;
        while (cnt < 4 && n < 60) begin
            @(negedge clk);
            n++;
            if (|done) cnt++;
        end
        req = 2'b00;
        chk("rr_done_count", 32'(cnt), 4);
        chk("rr_cycles", 32'(n), 15);

        // single request, completion 5 cycles after start
        repeat (2) @(negedge clk);
        run_txn(0, 3'b010, 16'h1234, 5, 1'b0, waited);
        chk("req_to_gnt", 32'(waited), 1);
        @(negedge clk);
        chk("busy_after", 32'(busy), 0);
        chk("nfc_cmd_hold", 32'(nfc_bus.nfc_cmd), 32'h2);
        chk("RWA_hold", 32'(nfc_bus.RWA), 32'h1234);

        // error path
        repeat (2) @(negedge clk);
        run_txn(1, 3'b111, 16'hCAFE, 2, 1'b1, waited);

        // watchdog, then sticky flag and clear
        repeat (2) @(negedge clk);
        run_txn(0, 3'b100, 16'h0F0F, 0, 1'b0, waited);
        repeat (3) @(negedge clk);
        chk("tf_sticky", 32'(timeout_flag), 1);
        timeout_clr = 1'b1;
        @(negedge clk);
        timeout_clr = 1'b0;
        tf_model = 1'b0;
        chk("tf_cleared", 32'(timeout_flag), 0);

        // reset in the middle of WAIT
        repeat (2) @(negedge clk);
        g.gnt = 2'b10;
        g.cmd = 3'b110;
        g.addr = 16'hDEAD;
        gq.push_back(g);
        mc_delay = 0;
        req_cmd[5:3] = 3'b110;
        req_addr[31:16] = 16'hDEAD;
        req[1] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = gnt[1];
        end
        chk("abort_gnt_wait", 32'(seen), 1);
        req[1] = 1'b0;
        repeat (3) @(negedge clk);
        #2 Reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_nfc_start", 32'(nfc_bus.nfc_start), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_err", 32'(err), 0);
        chk("mid_rst_nfc_cmd", 32'(nfc_bus.nfc_cmd), 0);
        chk("mid_rst_RWA", 32'(nfc_bus.RWA), 0);
        req_cmd[5:3] = 3'b011;
        req_addr[31:16] = 16'hBEEF;
        req = 2'b10;
        repeat (2) @(negedge clk);
        Reset_n = 1'b1;
        run_txn(1, 3'b011, 16'hBEEF, 1, 1'b0, waited);
        chk("post_rst_gnt_lat", 32'(waited), 1);

        // nfc_done on the last WAIT cycle beats the watchdog
        repeat (2) @(negedge clk);
        run_txn(1, 3'b001, 16'h5555, TMO, 1'b0, waited);
        @(negedge clk);
        chk("tf_after_race", 32'(timeout_flag), 0);

        repeat (3) @(negedge clk);
        chk("gnt_queue_left", 32'(gq.size()), 0);
        chk("resp_queue_left", 32'(rq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : guard
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
